// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - state encoding and velocity cap helper for step_ramp_gen
package stepper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCEL  = 3'd2,
        ST_CRUISE = 3'd3,
        ST_DECEL  = 3'd4
    } state_e;

    // Fastest velocity that still leaves a low gap as long as the high time
    function automatic longint unsigned vcap_calc(input int rate_w, input int step_high);
        return (64'd1 << rate_w) / longint'(2 * step_high);
    endfunction

endpackage

// File: rtl/step_pulse_stretch.sv
// rtl/step_pulse_stretch.sv - stretches a one-clock step event into a STEP_HIGH-clock pulse
module step_pulse_stretch #(
    parameter int STEP_HIGH = 25
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic event_i,
    output logic step_o,
    output logic pulse_active_o
);

    localparam int CW = $clog2(STEP_HIGH + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          step_q, step_d;

    always_comb begin
        cnt_d = cnt_q;
        if (event_i) begin
            cnt_d = CW'(STEP_HIGH);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
        step_d = (cnt_d != '0);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q  <= '0;
            step_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
        end
    end

    assign step_o         = step_q;
    assign pulse_active_o = step_q;

endmodule

// File: rtl/step_ramp_gen.sv
// rtl/step_ramp_gen.sv - trapezoidal-ramp step/direction generator
// Optional position counter: STEP_RAMP_POSITION_EN.
module step_ramp_gen
    import stepper_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RATE_W    = 24,
    parameter int ACC_DIV   = 25,
    parameter int STEP_HIGH = 25,
    parameter int DIR_SETUP = 50
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [WIDTH-1:0]  cmd_steps_i,
    input  logic [RATE_W-1:0] vmin_i,
    input  logic [RATE_W-1:0] vmax_i,
    input  logic [RATE_W-1:0] accel_i,
    input  logic              abort_i,
    output logic              step_o,
    output logic              dir_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic [WIDTH-1:0]  position_o
);

    localparam int SW = $clog2(DIR_SETUP + 1);
    localparam int DW = $clog2(ACC_DIV + 1);
    localparam logic [RATE_W-1:0] VCAP = RATE_W'(vcap_calc(RATE_W, STEP_HIGH));

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  remaining_q, remaining_d, ramp_cnt_q, ramp_cnt_d;
    logic [RATE_W-1:0] v_q, v_d, acc_q, acc_d;
    logic [RATE_W-1:0] vmin_q, vmin_d, vmax_q, vmax_d, accel_q, accel_d;
    logic [SW-1:0]     setup_cnt_q, setup_cnt_d;
    logic [DW-1:0]     div_cnt_q, div_cnt_d;
    logic              dir_q, dir_d, done_q, done_d, aborted_q, aborted_d;
    logic              abort_flag_q, abort_flag_d;

    logic [RATE_W:0]   acc_sum, v_up;
    logic [RATE_W-1:0] v_up_sat, v_inc, v_dec, vmax_clamp, vmin_clamp;
    logic [WIDTH-1:0]  cmd_mag;
    logic              stepping, step_event, vel_tick, pulse_active;

    assign stepping   = (state_q == ST_ACCEL) || (state_q == ST_CRUISE) || (state_q == ST_DECEL);
    assign acc_sum    = {1'b0, acc_q} + {1'b0, v_q};
    assign step_event = stepping && acc_sum[RATE_W] && (remaining_q != '0);
    assign vel_tick   = stepping && (div_cnt_q == DW'(ACC_DIV - 1));
    assign v_up       = {1'b0, v_q} + {1'b0, accel_q};
    assign v_up_sat   = v_up[RATE_W] ? '1 : v_up[RATE_W-1:0];
    assign v_inc      = (v_up_sat > vmax_q) ? vmax_q : v_up_sat;
    assign v_dec      = ((v_q >= accel_q) && ((v_q - accel_q) > vmin_q)) ? (v_q - accel_q) : vmin_q;
    assign cmd_mag    = cmd_steps_i[WIDTH-1] ? (~cmd_steps_i + WIDTH'(1)) : cmd_steps_i;

    // A zero cruise speed would stall the ramp, so it is raised like vmin
    always_comb begin
        vmax_clamp = (vmax_i > VCAP) ? VCAP : vmax_i;
        if (vmax_clamp == '0) vmax_clamp = RATE_W'(1);
        vmin_clamp = (vmin_i > vmax_clamp) ? vmax_clamp : vmin_i;
        if (vmin_clamp == '0) vmin_clamp = RATE_W'(1);
    end

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        ramp_cnt_d   = ramp_cnt_q;
        v_d          = v_q;
        acc_d        = acc_q;
        vmin_d       = vmin_q;
        vmax_d       = vmax_q;
        accel_d      = accel_q;
        setup_cnt_d  = setup_cnt_q;
        div_cnt_d    = div_cnt_q;
        dir_d        = dir_q;
        abort_flag_d = abort_flag_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;

        if (stepping) begin
            acc_d     = acc_sum[RATE_W-1:0];
            div_cnt_d = vel_tick ? '0 : div_cnt_q + DW'(1);
        end
        if (step_event) begin
            remaining_d = remaining_q - WIDTH'(1);
            if (state_q == ST_ACCEL) ramp_cnt_d = ramp_cnt_q + WIDTH'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_mag == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d      = ST_SETUP;
                        remaining_d  = cmd_mag;
                        dir_d        = ~cmd_steps_i[WIDTH-1];
                        vmin_d       = vmin_clamp;
                        vmax_d       = vmax_clamp;
                        accel_d      = accel_i;
                        setup_cnt_d  = '0;
                        abort_flag_d = 1'b0;
                    end
                end
            end
            ST_SETUP: begin
                if (abort_i) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (setup_cnt_q == SW'(DIR_SETUP - 1)) begin
                    state_d    = ST_ACCEL;
                    v_d        = vmin_q;
                    acc_d      = '0;
                    ramp_cnt_d = '0;
                    div_cnt_d  = '0;
                end else begin
                    setup_cnt_d = setup_cnt_q + SW'(1);
                end
            end
            ST_ACCEL, ST_CRUISE: begin
                if ((state_q == ST_ACCEL) && vel_tick) v_d = v_inc;
                // Keep only as many steps as the ramp down needs
                if (abort_i) begin
                    state_d      = ST_DECEL;
                    abort_flag_d = 1'b1;
                    if (remaining_d > ramp_cnt_d) remaining_d = ramp_cnt_d;
                end else if (remaining_q <= ramp_cnt_q) begin
                    state_d = ST_DECEL;
                end else if ((state_q == ST_ACCEL) && (v_q == vmax_q)) begin
                    state_d = ST_CRUISE;
                end
            end
            ST_DECEL: begin
                if (vel_tick) v_d = v_dec;
                if ((remaining_q == '0) && !pulse_active) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    aborted_d = abort_flag_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            ramp_cnt_q   <= '0;
            v_q          <= '0;
            acc_q        <= '0;
            vmin_q       <= '0;
            vmax_q       <= '0;
            accel_q      <= '0;
            setup_cnt_q  <= '0;
            div_cnt_q    <= '0;
            dir_q        <= 1'b0;
            abort_flag_q <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            ramp_cnt_q   <= ramp_cnt_d;
            v_q          <= v_d;
            acc_q        <= acc_d;
            vmin_q       <= vmin_d;
            vmax_q       <= vmax_d;
            accel_q      <= accel_d;
            setup_cnt_q  <= setup_cnt_d;
            div_cnt_q    <= div_cnt_d;
            dir_q        <= dir_d;
            abort_flag_q <= abort_flag_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    step_pulse_stretch #(.STEP_HIGH(STEP_HIGH)) u_stretch (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .event_i        (step_event),
        .step_o         (step_o),
        .pulse_active_o (pulse_active)
    );

`ifdef STEP_RAMP_POSITION_EN
    logic [WIDTH-1:0] position_q, position_d;

    always_comb begin
        position_d = position_q;
        if (step_event) position_d = dir_q ? position_q + WIDTH'(1) : position_q - WIDTH'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) position_q <= '0;
        else            position_q <= position_d;
    end

    assign position_o = position_q;
`else
    assign position_o = '0;
`endif

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign dir_o       = dir_q;
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;

endmodule
